// File: rtl/fibonacci_result_reader_if.sv
// Host/memory-side signal bundle for the Fibonacci result reader.
// The reader itself connects through the slave modport; the environment drives the master side.
interface fibonacci_result_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  fib_written;
  logic                  clear;
  logic                  rd_start;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  dump_done;
  logic                  busy;
  logic [ADDR_WIDTH:0]   result_count;
  logic                  overflow;

  modport slave (
    input  fib_written, clear, rd_start, rd_data, out_ready,
    output wr_addr, rd_en, rd_addr, out_data, out_valid, dump_done, busy,
           result_count, overflow
  );

  modport master (
    output fib_written, clear, rd_start, rd_data, out_ready,
    input  wr_addr, rd_en, rd_addr, out_data, out_valid, dump_done, busy,
           result_count, overflow
  );
endinterface

// File: rtl/fibonacci_result_reader.sv
// Result memory write-pointer owner and read-back engine: counts stored results and
// streams them to the host in address order over a valid/ready handshake.
module fibonacci_result_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         arst_n,
  fibonacci_result_reader_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state_r, state_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
  logic [ADDR_WIDTH-1:0] last_r, last_s;
  logic [ADDR_WIDTH:0]   count_r, count_s;
  logic [ADDR_WIDTH:0]   count_m1_s;
  logic                  overflow_r, overflow_s;
  logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  rd_en_r, out_valid_r, dump_done_r, busy_r;

  assign count_m1_s = count_r - COUNT_ONE;

  // Dump sequencing: snapshot the last index at start, walk ptr through READ/CAPTURE/SEND.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    last_s  = last_r;
    case (state_r)
      S_IDLE: begin
        if (bus.rd_start) begin
          if (count_r == COUNT_ZERO) begin
            state_s = S_DONE;
          end else begin
            last_s  = count_m1_s[ADDR_WIDTH-1:0];
            ptr_s   = ADDR_ZERO;
            state_s = S_READ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:    state_s = S_CAPTURE;
      S_CAPTURE: state_s = S_SEND;
      S_SEND: begin
        if (bus.out_ready) begin
          if (ptr_r == last_r) begin
            state_s = S_DONE;
          end else begin
            ptr_s   = ptr_r + ADDR_ONE;
            state_s = S_READ;
          end
        end else begin
          state_s = S_SEND;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Result counting runs in every state; clear only takes effect in IDLE and beats a write.
  always_comb begin
    count_s    = count_r;
    overflow_s = overflow_r;
    if ((state_r == S_IDLE) && bus.clear) begin
      count_s    = COUNT_ZERO;
      overflow_s = 1'b0;
    end else if (bus.fib_written) begin
      if (count_r == COUNT_FULL) begin
        overflow_s = 1'b1;
      end else begin
        count_s = count_r + COUNT_ONE;
      end
    end else begin
      count_s = count_r;
    end
    // Once full, further writes land on the final entry.
    if (count_s == COUNT_FULL) begin
      wr_addr_s = ADDR_LAST;
    end else begin
      wr_addr_s = count_s[ADDR_WIDTH-1:0];
    end
  end

  // State, pointers, counters and all host-visible outputs are registered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r     <= S_IDLE;
      ptr_r       <= ADDR_ZERO;
      last_r      <= ADDR_ZERO;
      count_r     <= COUNT_ZERO;
      overflow_r  <= 1'b0;
      wr_addr_r   <= ADDR_ZERO;
      out_data_r  <= DATA_ZERO;
      rd_en_r     <= 1'b0;
      out_valid_r <= 1'b0;
      dump_done_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      last_r      <= last_s;
      count_r     <= count_s;
      overflow_r  <= overflow_s;
      wr_addr_r   <= wr_addr_s;
      if (state_r == S_CAPTURE) begin
        out_data_r <= bus.rd_data;
      end else begin
        out_data_r <= out_data_r;
      end
      rd_en_r     <= (state_s == S_READ);
      out_valid_r <= (state_s == S_SEND);
      dump_done_r <= (state_s == S_DONE);
      busy_r      <= (state_s != S_IDLE);
    end
  end

  assign bus.wr_addr      = wr_addr_r;
  assign bus.rd_en        = rd_en_r;
  assign bus.rd_addr      = ptr_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.dump_done    = dump_done_r;
  assign bus.busy         = busy_r;
  assign bus.result_count = count_r;
  assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_fibonacci_result_reader.sv
// Directed bench for fibonacci_result_reader: a transaction-level model checked every
// cycle, plus hand-computed expectations for counts, timing and data.
module tb_fibonacci_result_reader;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [DW-1:0] wr_value = '0;
  logic [DW-1:0] mem [DEPTH];

  fibonacci_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  fibonacci_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Result memory: synchronous write, one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.fib_written) mem[bus.wr_addr] <= wr_value;
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_count;
  bit          m_ovf;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_q [$];
  bit          m_active;
  bit          m_done;
  int          m_phase;   // cycles left before the current word is offered
  int          m_idx;
  logic [DW-1:0] m_last;

  function automatic int exp_wr_addr();
    return (m_count < DEPTH) ? m_count : DEPTH - 1;
  endfunction

  function automatic void m_reset();
    m_count = 0; m_ovf = 0; m_active = 0; m_done = 0;
    m_phase = 0; m_idx = 0; m_last = '0; m_q.delete();
  endfunction

  function automatic void m_step();
    bit idle;
    idle = !m_active && !m_done;
    if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (m_phase > 0) begin
        m_phase--;
      end else if (bus.out_ready) begin
        m_last = m_q.pop_front();
        if (m_q.size() == 0) begin
          m_active = 0;
          m_done = 1;
        end else begin
          m_phase = 2;
          m_idx++;
        end
      end
    end else if (bus.rd_start) begin
      if (m_count == 0) begin
        m_done = 1;
      end else begin
        m_q.delete();
        for (int i = 0; i < m_count; i++) m_q.push_back(m_mem[i]);
        m_active = 1;
        m_phase = 2;
        m_idx = 0;
      end
    end
    if (idle && bus.clear) begin
      m_count = 0;
      m_ovf = 0;
    end else if (bus.fib_written) begin
      m_mem[exp_wr_addr()] = wr_value;
      if (m_count < DEPTH) m_count++;
      else m_ovf = 1;
    end
  endfunction

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!arst_n) m_reset();
      check("busy",         bus.busy,         m_active || m_done);
      check("out_valid",    bus.out_valid,    m_active && (m_phase == 0));
      check("rd_en",        bus.rd_en,        m_active && (m_phase == 2));
      check("dump_done",    bus.dump_done,    m_done);
      check("out_data",     bus.out_data,     (m_active && m_phase == 0) ? m_q[0] : m_last);
      check("rd_addr",      bus.rd_addr,      m_idx);
      check("result_count", bus.result_count, m_count);
      check("overflow",     bus.overflow,     m_ovf);
      check("wr_addr",      bus.wr_addr,      exp_wr_addr());
      if (arst_n) m_step();
    end
  end

  // ---------------- stimulus ----------------
  int acc_k [$];
  logic [DW-1:0] acc_d [$];
  int done_cnt;
  int done_k;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    wr_value = v;
    bus.fib_written = 1'b1;
    tick();
    bus.fib_written = 1'b0;
  endtask

  task automatic run_dump(input int stall_lo, input int stall_hi, input int max_k);
    acc_k.delete(); acc_d.delete(); done_cnt = 0; done_k = 0;
    bus.out_ready = 1'b1;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      bus.out_ready = (k >= stall_lo && k < stall_hi) ? 1'b0 : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        acc_k.push_back(k);
        acc_d.push_back(bus.out_data);
      end
      if (bus.dump_done) begin
        done_cnt++;
        done_k = k;
      end
      tick();
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic check_dump(input string tag, input int ek0, input int ek1, input int ek2, input int edone);
    int ek [3];
    logic [DW-1:0] ed [3];
    ek[0] = ek0; ek[1] = ek1; ek[2] = ek2;
    ed[0] = 32'd0; ed[1] = 32'd1; ed[2] = 32'd1;
    check({tag, "_words"}, acc_k.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_accept_cycle"}, (acc_k.size() > i) ? acc_k[i] : -1, ek[i]);
      check({tag, "_data"}, (acc_d.size() > i) ? acc_d[i] : 32'hDEAD_BEEF, ed[i]);
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_k, edone);
    check({tag, "_busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      m_mem[i] = '0;
    end
    bus.fib_written = 1'b0; bus.clear = 1'b0; bus.rd_start = 1'b0;
    bus.out_ready = 1'b1; bus.rd_data = '0;

    tick(); tick();
    check("reset_count", bus.result_count, 0);
    check("reset_valid", bus.out_valid, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    arst_n = 1'b1;
    tick();

    // Three stored results 0,1,1
    check("wr_addr_0", bus.wr_addr, 0);
    write_word(32'd0); check("wr_addr_1", bus.wr_addr, 1);
    write_word(32'd1); check("wr_addr_2", bus.wr_addr, 2);
    write_word(32'd1); check("wr_addr_3", bus.wr_addr, 3);
    check("count_3", bus.result_count, 3);
    check("ovf_0", bus.overflow, 1'b0);
    tick();

    // Free-flowing dump: accepts at 3,6,9, done at 10
    run_dump(0, 0, 14);
    check_dump("dump_free", 3, 6, 9, 10);

    // Host stalls word 2 for four cycles
    run_dump(6, 10, 18);
    check_dump("dump_stall", 3, 10, 13, 14);

    // Empty dump
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    check("clear_count", bus.result_count, 0);
    bus.rd_start = 1'b1; tick(); bus.rd_start = 1'b0;
    check("empty_busy", bus.busy, 1'b1);
    check("empty_done", bus.dump_done, 1'b1);
    check("empty_rd_en", bus.rd_en, 1'b0);
    tick();
    check("empty_busy_after", bus.busy, 1'b0);
    check("empty_done_after", bus.dump_done, 1'b0);

    // Overflow and clear
    for (int i = 0; i < 33; i++) write_word(32'(i + 100));
    check("full_count", bus.result_count, 32);
    check("full_wr_addr", bus.wr_addr, 31);
    check("full_ovf", bus.overflow, 1'b1);
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    check("clr_count", bus.result_count, 0);
    check("clr_ovf", bus.overflow, 1'b0);
    write_word(32'd7);
    bus.clear = 1'b1; bus.fib_written = 1'b1; tick();
    bus.clear = 1'b0; bus.fib_written = 1'b0;
    check("clr_wins", bus.result_count, 0);
    check("clr_wins_addr", bus.wr_addr, 0);

    // Write and clear during a two-word dump
    write_word(32'd10); write_word(32'd20);
    bus.rd_start = 1'b1; tick(); bus.rd_start = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      bus.fib_written = (k == 2) ? 1'b1 : 1'b0;
      bus.clear = (k == 4) ? 1'b1 : 1'b0;
      wr_value = 32'd30;
      if (bus.out_valid && bus.out_ready) n++;
      tick();
    end
    bus.fib_written = 1'b0; bus.clear = 1'b0;
    check("busy_dump_words", n, 2);
    check("busy_dump_count", bus.result_count, 3);

    // Reset while a word is being offered
    bus.out_ready = 1'b0;
    bus.rd_start = 1'b1; tick(); bus.rd_start = 1'b0;
    tick(); tick();
    check("pre_reset_valid", bus.out_valid, 1'b1);
    check("pre_reset_data", bus.out_data, 32'd10);
    arst_n = 1'b0;
    #1;
    check("reset_mid_valid", bus.out_valid, 1'b0);
    check("reset_mid_busy", bus.busy, 1'b0);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.dump_done) n++;
      tick();
    end
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (bus.dump_done) n++;
      tick();
    end
    check("reset_no_done", n, 0);
    check("reset_idle", bus.busy, 1'b0);
    bus.out_ready = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
